// File: rtl/voice_scheduler.sv
// -----------------------------------------------------------------------------
// voice_scheduler
//
// Purpose: drives the per-sample sweep of the envelope pipeline and allocates
// voices to incoming MIDI note events. Two independent machines share one
// clock:
//   * sequencer - IDLE/RUN. One i_sample_tick starts a sweep that visits every
//     voice for three cycles (read, compute, update). A sweep is
//     3*NUM_VOICES cycles.
//   * allocator - READY/SEARCH/ISSUE. It keeps a busy bit and a 7-bit note per
//     voice. It resolves one note event at a time. The resulting keystate
//     update is handed to the envelope block only in a phase-0 cycle of a
//     running sweep.
//
// Optional feature: define VOICE_STEAL_EN to have a note-on steal a voice in
// round-robin order when every voice is busy. Without the macro, such a
// note-on is dropped and flagged on o_drop.
//
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_sample_tick           one-cycle pulse that starts a sample frame
//   i_note_valid/o_note_ready, i_note_on, i_note_num
//                           note event handshake (on/off and MIDI note)
//   o_voice_index           voice currently in the envelope pipeline
//   o_pipeline_state        0 read, 1 compute, 2 update, 3 idle
//   o_adsr_flag             one-cycle keystate-update strobe
//   o_adsr_note_status      keystate carried with the strobe (1 = on)
//   o_adsr_voice_index      target voice carried with the strobe
//   o_voice_note            note table, voice v in bits [7v+6:7v]
//   o_frame_done            pulse in the first cycle after a sweep ends
//   o_overrun               pulse after a tick that arrived mid-sweep
//   o_drop                  pulse after a note-on that got no voice
// -----------------------------------------------------------------------------
module voice_scheduler #(
   parameter int NUM_VOICES = 16
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic                    i_sample_tick,
   input  logic                    i_note_valid,
   input  logic                    i_note_on,
   input  logic [6:0]              i_note_num,
   output logic                    o_note_ready,
   output logic [7:0]              o_voice_index,
   output logic [1:0]              o_pipeline_state,
   output logic                    o_adsr_flag,
   output logic                    o_adsr_note_status,
   output logic [7:0]              o_adsr_voice_index,
   output logic [7*NUM_VOICES-1:0] o_voice_note,
   output logic                    o_frame_done,
   output logic                    o_overrun,
   output logic                    o_drop
);

   localparam int IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

   localparam logic [0:0] SEQ_IDLE = 1'b0;
   localparam logic [0:0] SEQ_RUN  = 1'b1;

   localparam logic [1:0] AL_READY  = 2'd0;
   localparam logic [1:0] AL_SEARCH = 2'd1;
   localparam logic [1:0] AL_ISSUE  = 2'd2;

   localparam logic [7:0]    LAST_VOICE   = 8'(NUM_VOICES - 1);
   localparam logic [IW-1:0] LAST_VOICE_I = IW'(NUM_VOICES - 1);

   // ---------------------------------------------------------------------------
   // Sequencer
   // ---------------------------------------------------------------------------
   logic [0:0] seq_state_q, seq_state_d;
   logic [7:0] voice_idx_q, voice_idx_d;
   logic [1:0] phase_q, phase_d;
   logic       frame_done_q, frame_done_d;
   logic       overrun_q, overrun_d;

   always_comb begin
      seq_state_d  = seq_state_q;
      voice_idx_d  = voice_idx_q;
      phase_d      = phase_q;
      frame_done_d = 1'b0;
      overrun_d    = 1'b0;
      case (seq_state_q)
         SEQ_IDLE: begin
            if (i_sample_tick) begin
               seq_state_d = SEQ_RUN;
               voice_idx_d = '0;
               phase_d     = 2'd0;
            end
         end
         default: begin
            // A tick during a sweep is reported but never restarts it.
            overrun_d = i_sample_tick;
            if (phase_q == 2'd2) begin
               phase_d = 2'd0;
               if (voice_idx_q == LAST_VOICE) begin
                  seq_state_d  = SEQ_IDLE;
                  voice_idx_d  = '0;
                  frame_done_d = 1'b1;
               end else begin
                  voice_idx_d = voice_idx_q + 8'd1;
               end
            end else begin
               phase_d = phase_q + 2'd1;
            end
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         seq_state_q  <= SEQ_IDLE;
         voice_idx_q  <= '0;
         phase_q      <= 2'd0;
         frame_done_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         seq_state_q  <= seq_state_d;
         voice_idx_q  <= voice_idx_d;
         phase_q      <= phase_d;
         frame_done_q <= frame_done_d;
         overrun_q    <= overrun_d;
      end
   end

   // Strobe slot: first cycle of each voice slot in a running sweep.
   logic issue_slot;
   assign issue_slot = (seq_state_q == SEQ_RUN) && (phase_q == 2'd0);

   // ---------------------------------------------------------------------------
   // Allocator
   // ---------------------------------------------------------------------------
   logic [1:0]                 al_state_q, al_state_d;
   logic                       ev_on_q, ev_on_d;
   logic [6:0]                 ev_note_q, ev_note_d;
   logic [NUM_VOICES-1:0]      busy_q, busy_d;
   logic [NUM_VOICES-1:0][6:0] note_q, note_d;
   logic                       iss_status_q, iss_status_d;
   logic [IW-1:0]              iss_voice_q, iss_voice_d;
   logic                       drop_q, drop_d;
`ifdef VOICE_STEAL_EN
   logic [IW-1:0]              steal_ptr_q, steal_ptr_d;
`endif

   // Lowest busy voice holding the registered note (retrigger / note-off
   // target) and lowest free voice (fresh allocation).
   logic          hit_found, free_found;
   logic [IW-1:0] hit_idx, free_idx;

   always_comb begin
      hit_found  = 1'b0;
      hit_idx    = '0;
      free_found = 1'b0;
      free_idx   = '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
         if (!hit_found && busy_q[v] && (note_q[v] == ev_note_q)) begin
            hit_found = 1'b1;
            hit_idx   = IW'(v);
         end
         if (!free_found && !busy_q[v]) begin
            free_found = 1'b1;
            free_idx   = IW'(v);
         end
      end
   end

   always_comb begin
      al_state_d   = al_state_q;
      ev_on_d      = ev_on_q;
      ev_note_d    = ev_note_q;
      busy_d       = busy_q;
      note_d       = note_q;
      iss_status_d = iss_status_q;
      iss_voice_d  = iss_voice_q;
      drop_d       = 1'b0;
`ifdef VOICE_STEAL_EN
      steal_ptr_d  = steal_ptr_q;
`endif
      case (al_state_q)
         AL_READY: begin
            if (i_note_valid) begin
               ev_on_d    = i_note_on;
               ev_note_d  = i_note_num;
               al_state_d = AL_SEARCH;
            end
         end
         AL_SEARCH: begin
            if (ev_on_q) begin
               // Retrigger beats a fresh allocation, so one note never
               // occupies two voices.
               if (hit_found || free_found) begin
                  iss_voice_d          = hit_found ? hit_idx : free_idx;
                  busy_d[iss_voice_d]  = 1'b1;
                  note_d[iss_voice_d]  = ev_note_q;
                  iss_status_d         = 1'b1;
                  al_state_d           = AL_ISSUE;
               end else begin
`ifdef VOICE_STEAL_EN
                  iss_voice_d          = steal_ptr_q;
                  note_d[steal_ptr_q]  = ev_note_q;
                  iss_status_d         = 1'b1;
                  steal_ptr_d          = (steal_ptr_q == LAST_VOICE_I) ? '0
                                         : steal_ptr_q + IW'(1);
                  al_state_d           = AL_ISSUE;
`else
                  drop_d               = 1'b1;
                  al_state_d           = AL_READY;
`endif
               end
            end else if (hit_found) begin
               // Note stays in the table; only the busy bit is released.
               iss_voice_d      = hit_idx;
               busy_d[hit_idx]  = 1'b0;
               iss_status_d     = 1'b0;
               al_state_d       = AL_ISSUE;
            end else begin
               al_state_d = AL_READY;
            end
         end
         AL_ISSUE: begin
            if (issue_slot) al_state_d = AL_READY;
         end
         default: al_state_d = AL_READY;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         al_state_q   <= AL_READY;
         ev_on_q      <= 1'b0;
         ev_note_q    <= '0;
         busy_q       <= '0;
         note_q       <= '0;
         iss_status_q <= 1'b0;
         iss_voice_q  <= '0;
         drop_q       <= 1'b0;
`ifdef VOICE_STEAL_EN
         steal_ptr_q  <= '0;
`endif
      end else begin
         al_state_q   <= al_state_d;
         ev_on_q      <= ev_on_d;
         ev_note_q    <= ev_note_d;
         busy_q       <= busy_d;
         note_q       <= note_d;
         iss_status_q <= iss_status_d;
         iss_voice_q  <= iss_voice_d;
         drop_q       <= drop_d;
`ifdef VOICE_STEAL_EN
         steal_ptr_q  <= steal_ptr_d;
`endif
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign o_note_ready       = (al_state_q == AL_READY);
   assign o_voice_index      = voice_idx_q;
   assign o_pipeline_state   = (seq_state_q == SEQ_RUN) ? phase_q : 2'd3;
   // ISSUE leaves on the strobe cycle, so the strobe lasts exactly one cycle.
   assign o_adsr_flag        = (al_state_q == AL_ISSUE) && issue_slot;
   assign o_adsr_note_status = iss_status_q;
   assign o_adsr_voice_index = 8'(iss_voice_q);
   assign o_voice_note       = note_q;
   assign o_frame_done       = frame_done_q;
   assign o_overrun          = overrun_q;
   assign o_drop             = drop_q;

endmodule

// File: tb/tb_voice_scheduler.sv
module tb_voice_scheduler;
   localparam int NV = 16;

   logic            i_clk = 1'b0;
   logic            i_reset, i_sample_tick, i_note_valid, i_note_on;
   logic [6:0]      i_note_num;
   logic            o_note_ready, o_adsr_flag, o_adsr_note_status;
   logic [7:0]      o_voice_index, o_adsr_voice_index;
   logic [1:0]      o_pipeline_state;
   logic [7*NV-1:0] o_voice_note;
   logic            o_frame_done, o_overrun, o_drop;

   voice_scheduler #(.NUM_VOICES(NV)) dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_sample_tick(i_sample_tick),
      .i_note_valid(i_note_valid), .i_note_on(i_note_on), .i_note_num(i_note_num),
      .o_note_ready(o_note_ready), .o_voice_index(o_voice_index),
      .o_pipeline_state(o_pipeline_state), .o_adsr_flag(o_adsr_flag),
      .o_adsr_note_status(o_adsr_note_status), .o_adsr_voice_index(o_adsr_voice_index),
      .o_voice_note(o_voice_note), .o_frame_done(o_frame_done),
      .o_overrun(o_overrun), .o_drop(o_drop)
   );

   always #5 i_clk = ~i_clk;

   int n_chk = 0;
   int n_pass = 0;

   // Reference model: voice table as plain arrays.
   bit m_busy[NV];
   int m_note[NV];
   int m_steal;

   function automatic void model_reset();
      for (int v = 0; v < NV; v++) begin m_busy[v] = 0; m_note[v] = 0; end
      m_steal = 0;
   endfunction

   // kind: 0 = no strobe, 1 = strobe, 2 = drop
   function automatic void model_event(input bit on_i, input int nn,
                                       output int kind, output int voice, output bit st);
      int hit = -1, fr = -1;
      for (int v = NV - 1; v >= 0; v--) begin
         if (m_busy[v] && m_note[v] == nn) hit = v;
         if (!m_busy[v]) fr = v;
      end
      kind = 0; voice = -1; st = on_i;
      if (on_i) begin
         if (hit >= 0) voice = hit;
         else if (fr >= 0) voice = fr;
         else begin
`ifdef VOICE_STEAL_EN
            voice = m_steal;
            m_steal = (m_steal + 1) % NV;
`else
            kind = 2;
            return;
`endif
         end
         kind = 1; m_busy[voice] = 1; m_note[voice] = nn;
      end else if (hit >= 0) begin
         kind = 1; voice = hit; m_busy[hit] = 0;
      end
   endfunction

   task automatic do_reset();
      @(posedge i_clk); #1;
      i_reset = 1; i_sample_tick = 0; i_note_valid = 0; i_note_on = 0; i_note_num = 0;
      @(posedge i_clk); @(posedge i_clk); #1;
      i_reset = 0;
      model_reset();
   endtask

   // Offers one event, keeps sweeps running (tick whenever idle) and records
   // what came back until o_note_ready is seen again.
   task automatic do_event(input bit on_i, input int nn,
                           output int flags, output int fvoice, output bit fstat,
                           output int fvidx, output bit fphase_ok, output int drops,
                           output int ovr, output int lat, output bit tmo);
      bit acc, done, tick_next;
      flags = 0; fvoice = -1; fstat = 0; fvidx = -1; fphase_ok = 1;
      drops = 0; ovr = 0; lat = 0; tmo = 0; acc = 0; done = 0;
      @(posedge i_clk); #1;
      i_note_valid = 1; i_note_on = on_i; i_note_num = 7'(nn); i_sample_tick = 0;
      for (int k = 0; k < 400 && !acc; k++) begin
         @(negedge i_clk);
         if (o_note_ready) acc = 1;
         else begin
            tick_next = (o_pipeline_state == 2'd3) && !i_sample_tick;
            @(posedge i_clk); #1; i_sample_tick = tick_next;
         end
      end
      @(posedge i_clk); #1;
      i_note_valid = 0; i_sample_tick = 0;
      if (!acc) begin tmo = 1; return; end
      for (int c = 1; c <= 400 && !done; c++) begin
         @(negedge i_clk);
         if (o_adsr_flag) begin
            flags++; fvoice = o_adsr_voice_index; fstat = o_adsr_note_status;
            fvidx = o_voice_index;
            if (o_pipeline_state != 2'd0) fphase_ok = 0;
         end
         if (o_drop) drops++;
         if (o_overrun) ovr++;
         if (o_note_ready) begin lat = c; done = 1; end
         else begin
            tick_next = (o_pipeline_state == 2'd3) && !i_sample_tick;
            @(posedge i_clk); #1; i_sample_tick = tick_next;
         end
      end
      if (!done) tmo = 1;
   endtask

   // Event plus full comparison against the model.
   task automatic check_event(input string nm, input bit on_i, input int nn);
      int flags, fvoice, fvidx, drops, ovr, lat, kind, ev;
      bit fstat, fph, tmo, est;
      model_event(on_i, nn, kind, ev, est);
      do_event(on_i, nn, flags, fvoice, fstat, fvidx, fph, drops, ovr, lat, tmo);
      n_chk++; if (tmo) $display("FAIL %s timeout: ready never returned", nm); else n_pass++;
      n_chk++; if (flags !== (kind == 1 ? 1 : 0)) $display("FAIL %s strobes: got %0d want %0d", nm, flags, kind == 1); else n_pass++;
      n_chk++; if (drops !== (kind == 2 ? 1 : 0)) $display("FAIL %s drop: got %0d want %0d", nm, drops, kind == 2); else n_pass++;
      n_chk++; if (ovr !== 0) $display("FAIL %s overrun: got %0d want 0", nm, ovr); else n_pass++;
      if (kind == 1) begin
         n_chk++; if (fvoice !== ev) $display("FAIL %s voice: got %0d want %0d", nm, fvoice, ev); else n_pass++;
         n_chk++; if (fstat !== est) $display("FAIL %s status: got %0d want %0d", nm, fstat, est); else n_pass++;
         n_chk++; if (!fph) $display("FAIL %s strobe phase: got nonzero want 0", nm); else n_pass++;
         if (on_i) begin
            n_chk++;
            if (o_voice_note[7*ev +: 7] !== 7'(nn))
               $display("FAIL %s note table: got %0d want %0d", nm, o_voice_note[7*ev +: 7], nn);
            else n_pass++;
         end
      end
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge i_clk);
      n_chk++; if (o_pipeline_state !== 2'd3) $display("FAIL reset pstate: got %0d want 3", o_pipeline_state); else n_pass++;
      n_chk++; if (o_voice_index !== 8'd0) $display("FAIL reset vidx: got %0d want 0", o_voice_index); else n_pass++;
      n_chk++; if (o_note_ready !== 1'b1) $display("FAIL reset ready: got %0d want 1", o_note_ready); else n_pass++;
      n_chk++; if (o_voice_note !== '0) $display("FAIL reset note table: got %h want 0", o_voice_note); else n_pass++;
      n_chk++;
      if ({o_adsr_flag, o_adsr_note_status, o_adsr_voice_index, o_frame_done, o_overrun, o_drop} !== 13'd0)
         $display("FAIL reset strobes: got %b want 0",
                  {o_adsr_flag, o_adsr_note_status, o_adsr_voice_index, o_frame_done, o_overrun, o_drop});
      else n_pass++;
   endtask

   // Sweep with an optional extra tick at sweep cycle tick_at (-1 = none).
   task automatic run_sweep(input string nm, input int tick_at);
      int ovr = 0;
      do_reset();
      @(posedge i_clk); #1; i_sample_tick = 1;
      @(posedge i_clk); #1; i_sample_tick = 0;
      for (int c = 0; c <= 50; c++) begin
         @(negedge i_clk);
         if (o_overrun) ovr++;
         if (c < 3 * NV) begin
            n_chk++;
            if (o_pipeline_state !== 2'(c % 3) || o_voice_index !== 8'(c / 3) || o_frame_done !== 1'b0)
               $display("FAIL %s cycle %0d: got ps=%0d v=%0d fd=%0d want ps=%0d v=%0d fd=0",
                        nm, c, o_pipeline_state, o_voice_index, o_frame_done, c % 3, c / 3);
            else n_pass++;
         end else if (c == 3 * NV) begin
            n_chk++; if (o_frame_done !== 1'b1) $display("FAIL %s frame_done: got %0d want 1", nm, o_frame_done); else n_pass++;
            n_chk++; if (o_pipeline_state !== 2'd3) $display("FAIL %s end pstate: got %0d want 3", nm, o_pipeline_state); else n_pass++;
         end else if (c == 3 * NV + 1) begin
            n_chk++; if (o_frame_done !== 1'b0) $display("FAIL %s frame_done width: got %0d want 0", nm, o_frame_done); else n_pass++;
         end
         @(posedge i_clk); #1; i_sample_tick = (c + 1 == tick_at);
      end
      n_chk++;
      if (ovr !== (tick_at >= 0 ? 1 : 0)) $display("FAIL %s overrun count: got %0d want %0d", nm, ovr, tick_at >= 0);
      else n_pass++;
   endtask

   task automatic test_sweep();   run_sweep("sweep", -1); endtask
   task automatic test_overrun(); run_sweep("overrun", 10); endtask

   task automatic test_first_strobe();
      int flags, fvoice, fvidx, drops, ovr, lat, kind, ev;
      bit fstat, fph, tmo, est;
      do_reset();
      model_event(1, 60, kind, ev, est);
      do_event(1, 60, flags, fvoice, fstat, fvidx, fph, drops, ovr, lat, tmo);
      n_chk++;
      if (tmo || flags != 1 || fvoice != 0 || fstat != 1 || fvidx != 0 || !fph)
         $display("FAIL first strobe: got n=%0d v=%0d st=%0d slot=%0d want n=1 v=0 st=1 slot=0",
                  flags, fvoice, fstat, fvidx);
      else n_pass++;
      n_chk++; if (o_voice_note[6:0] !== 7'd60) $display("FAIL first note: got %0d want 60", o_voice_note[6:0]); else n_pass++;
   endtask

   task automatic test_on_off_reuse();
      do_reset();
      check_event("on60", 1, 60);
      check_event("on62", 1, 62);
      check_event("off60", 0, 60);
      check_event("on64", 1, 64);
      n_chk++; if (o_voice_note[6:0] !== 7'd64) $display("FAIL reuse v0 note: got %0d want 64", o_voice_note[6:0]); else n_pass++;
      check_event("retrig62", 1, 62);
   endtask

   task automatic test_nomatch_off();
      int flags, fvoice, fvidx, drops, ovr, lat;
      bit fstat, fph, tmo;
      do_reset();
      do_event(0, 50, flags, fvoice, fstat, fvidx, fph, drops, ovr, lat, tmo);
      n_chk++;
      if (tmo || flags != 0 || lat > 2)
         $display("FAIL nomatch off: got strobes=%0d latency=%0d want 0 and <=2", flags, lat);
      else n_pass++;
   endtask

   task automatic test_full();
      do_reset();
      for (int i = 0; i < NV; i++) check_event("fill", 1, 20 + i);
      check_event("overflow", 1, 99);
      check_event("overflow2", 1, 100);
   endtask

   task automatic test_reset_in_issue();
      int fl = 0;
      do_reset();
      @(posedge i_clk); #1; i_note_valid = 1; i_note_on = 1; i_note_num = 7'd70;
      @(posedge i_clk); #1; i_note_valid = 0;
      repeat (3) @(posedge i_clk);
      #1; i_reset = 1;
      @(posedge i_clk); #1; i_reset = 0; i_sample_tick = 1;
      @(posedge i_clk); #1; i_sample_tick = 0;
      for (int c = 0; c < 3 * NV + 2; c++) begin
         @(negedge i_clk);
         if (o_adsr_flag) fl++;
      end
      n_chk++; if (fl !== 0) $display("FAIL reset issue strobes: got %0d want 0", fl); else n_pass++;
      n_chk++; if (o_voice_note !== '0 || o_note_ready !== 1'b1)
         $display("FAIL reset issue table: got %h rdy=%0d want 0 rdy=1", o_voice_note, o_note_ready);
      else n_pass++;
      model_reset();
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 70; i++)
         check_event("rand", ($urandom_range(0, 99) < 65), 30 + $urandom_range(0, 23));
   endtask

   initial begin
      i_reset = 1; i_sample_tick = 0; i_note_valid = 0; i_note_on = 0; i_note_num = 0;
      test_reset();
      test_sweep();
      test_overrun();
      test_first_strobe();
      test_on_off_reuse();
      test_nomatch_off();
      test_full();
      test_reset_in_issue();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("%0d/%0d checks passed", n_pass, n_chk + 1);
      $fatal(1);
   end
endmodule

// File: doc/voice_scheduler.md
VOICE_SCHEDULER -- requirements
Module: voice_scheduler

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 16, number of active voices (2..256).
REQ-002 SHALL have input i_clk, 1 bit, system clock; all logic on its rising edge.
REQ-003 SHALL have input i_reset, 1 bit, synchronous, active-high reset.
REQ-004 SHALL have input i_sample_tick, 1 bit, one-cycle pulse starting one sample frame.
REQ-005 SHALL have input i_note_valid, 1 bit, note event offered.
REQ-006 SHALL have input i_note_on, 1 bit, 1 = note-on, 0 = note-off.
REQ-007 SHALL have input i_note_num, 7 bits, MIDI note number.
REQ-008 SHALL have output o_note_ready, 1 bit, event accepted when i_note_valid & o_note_ready.
REQ-009 SHALL have output o_voice_index, 8 bits, voice currently in the envelope pipeline.
REQ-010 SHALL have output o_pipeline_state, 2 bits, pipeline phase: 0 read, 1 compute, 2 update, 3 idle.
REQ-011 SHALL have output o_adsr_flag, 1 bit, one-cycle keystate-update strobe to the envelope block.
REQ-012 SHALL have output o_adsr_note_status, 1 bit, keystate carried with o_adsr_flag.
REQ-013 SHALL have output o_adsr_voice_index, 8 bits, target voice carried with o_adsr_flag.
REQ-014 SHALL have output o_voice_note, 7 x NUM_VOICES bits, flattened note table; voice v in bits [7v+6:7v].
REQ-015 SHALL have output o_frame_done, 1 bit, one-cycle pulse at end of sweep.
REQ-016 SHALL have output o_overrun, 1 bit, one-cycle pulse on a tick arriving mid-sweep.
REQ-017 SHALL have output o_drop, 1 bit, one-cycle pulse on a note-on with no voice assigned.

Function
REQ-018 Sequencer SHALL have states IDLE and RUN; in IDLE, o_pipeline_state = 3.
REQ-019 IDLE + i_sample_tick SHALL move to RUN next cycle with o_voice_index = 0 and o_pipeline_state = 0.
REQ-020 In RUN, o_pipeline_state SHALL step 0->1->2 each cycle; after phase 2, o_voice_index SHALL increment and phase SHALL return to 0.
REQ-021 At voice NUM_VOICES-1, phase 2 -> IDLE next cycle with o_frame_done pulsed in that cycle; a sweep is 3*NUM_VOICES cycles.
REQ-022 i_sample_tick in RUN SHALL be ignored, pulse o_overrun, and not restart the sweep.
REQ-023 Allocator SHALL hold a busy bit and a 7-bit note per voice.
REQ-024 Allocator SHALL have states READY, SEARCH and ISSUE; o_note_ready = 1 only in READY.
REQ-025 An accepted event SHALL be registered and the allocator SHALL enter SEARCH.
REQ-026 Note-on in SEARCH SHALL choose the lowest-index non-busy voice, set its busy bit and note, and go to ISSUE with status 1.
REQ-027 Note-on for a note already busy on voice v SHALL reuse v (retrigger) without allocating a second voice.
REQ-028 Note-off in SEARCH SHALL find the lowest-index busy voice with a matching note, clear its busy bit, and go to ISSUE with status 0; if none matches, it SHALL return to READY with no strobe.
REQ-029 ISSUE SHALL assert o_adsr_flag for exactly one cycle, only when sequencer is RUN and o_pipeline_state = 0, then return to READY; the strobe SHALL therefore wait for the next sweep if needed.
REQ-030 At most one o_adsr_flag SHALL occur per voice slot (3 cycles).
REQ-031 o_adsr_note_status and o_adsr_voice_index SHALL be stable while o_adsr_flag = 1.
REQ-032 Sequencer and allocator SHALL run concurrently; allocation SHALL never stall the sweep.

Reset
REQ-033 On i_reset: sequencer SHALL be IDLE; o_voice_index = 0; o_pipeline_state = 3; allocator SHALL be READY; all busy bits = 0; o_voice_note = 0.
REQ-034 On i_reset: o_adsr_flag, o_adsr_note_status, o_adsr_voice_index, o_frame_done, o_overrun and o_drop SHALL be 0.
REQ-035 Reset mid-sweep or in ISSUE SHALL discard the pending event without emitting a strobe.

Configuration
REQ-036 Macro VOICE_STEAL_EN defined: all-busy note-on SHALL steal the voice at a round-robin steal pointer, overwrite its note, issue status 1, and advance the pointer modulo NUM_VOICES; o_drop is never asserted.
REQ-037 Macro VOICE_STEAL_EN undefined: all-busy note-on SHALL pulse o_drop, return to READY, and issue no strobe.

Verification
REQ-038 Reset, then tick -> o_pipeline_state 0,1,2 for voices 0..15; o_frame_done pulses 48 cycles after RUN entry; then o_pipeline_state = 3.
REQ-039 Note-on 60 while IDLE, then tick -> strobe (voice 0, status 1) in the first phase-0 cycle; o_voice_note[6:0] = 60.
REQ-040 Note-on 60, 62, then note-off 60 -> strobes voice 0 on, voice 1 on, voice 0 off; the next note-on 64 gets voice 0.
REQ-041 Tick at cycle 10 of a sweep -> o_overrun pulses once and the sweep ends on schedule.
REQ-042 17 note-ons with NUM_VOICES = 16 -> 17th gives o_drop without VOICE_STEAL_EN, or a steal strobe to voice 0 with it.
REQ-043 Note-off 50 with no voice holding note 50 -> no strobe; o_note_ready returns within 2 cycles.
